// File: rtl/hilo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_ctrl_pkg
// Purpose  : Shared encodings for the HiLo multiply/divide sequencer:
//            Op codes, FSM state encoding, divider step count and the
//            Op -> write-strobe mapping.
// Revision : 1.0  initial release
// ============================================================================
package hilo_ctrl_pkg;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MADD  = 4'd4;
   localparam logic [3:0] OP_MADDU = 4'd5;
   localparam logic [3:0] OP_MSUB  = 4'd6;
   localparam logic [3:0] OP_MSUBU = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;
   localparam logic [3:0] OP_MTLO  = 4'd9;

   localparam int DIV_STEPS = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MUL   = 3'd1,
      ST_DIV   = 3'd2,
      ST_FIX   = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      STB_NONE = 2'd0,
      STB_WE   = 2'd1,
      STB_MADD = 2'd2,
      STB_MSUB = 2'd3
   } strobe_t;

   // Which HiLo write strobe an op produces; STB_NONE marks reserved codes.
   function automatic strobe_t op_strobe(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
         OP_MTHI, OP_MTLO:    op_strobe = STB_WE;
         OP_MADD, OP_MADDU:   op_strobe = STB_MADD;
         OP_MSUB, OP_MSUBU:   op_strobe = STB_MSUB;
         default:             op_strobe = STB_NONE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_div_unit
// Purpose  : Iterative restoring divider on 32-bit unsigned magnitudes.
//            One quotient bit per cycle, DIV_STEPS cycles after Go.
// Ports    : Clk, Rst_n (async active-low)
//            Go        - load operands and start (single-cycle pulse)
//            Dividend  - unsigned dividend, sampled with Go
//            Divisor   - unsigned divisor, sampled with Go (non-zero)
//            Quotient  - result, held until the next Go
//            Remainder - result, held until the next Go
//            DivDone   - one-cycle pulse once the last step has completed
// Revision : 1.0  initial release
// ============================================================================
module hilo_div_unit
   import hilo_ctrl_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Go,
   input  logic [31:0] Dividend,
   input  logic [31:0] Divisor,
   output logic [31:0] Quotient,
   output logic [31:0] Remainder,
   output logic        DivDone
);

   localparam int              C_CNT_W = $clog2(DIV_STEPS);
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DIV_STEPS - 1);

   logic [31:0]        r_quo;
   logic [31:0]        r_rem;
   logic [31:0]        r_dvs;
   logic [C_CNT_W-1:0] r_cnt;
   logic               r_run;
   logic               r_done;
   logic [32:0]        w_shift;
   logic [32:0]        w_diff;

   // The partial remainder stays below the divisor, so the shifted value is
   // below twice the divisor: bit 32 of the difference is a clean borrow.
   assign w_shift = {r_rem, r_quo[31]};
   assign w_diff  = w_shift - {1'b0, r_dvs};

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_quo  <= '0;
         r_rem  <= '0;
         r_dvs  <= '0;
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (Go) begin
            r_quo <= Dividend;
            r_rem <= '0;
            r_dvs <= Divisor;
            r_cnt <= '0;
            r_run <= 1'b1;
         end else if (r_run) begin
            if (!w_diff[32]) begin
               r_rem <= w_diff[31:0];
               r_quo <= {r_quo[30:0], 1'b1};
            end else begin
               r_rem <= w_shift[31:0];
               r_quo <= {r_quo[30:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign Quotient  = r_quo;
   assign Remainder = r_rem;
   assign DivDone   = r_done;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl
// Purpose  : Sequencer between decode and the HiLo register file. Runs a
//            fixed-latency multiply or a 32-step divide (or a move to Hi/Lo)
//            and issues exactly one write strobe with the result data.
//            Generates Stall when a HiLo op or mfhi/mflo read collides with
//            an op in flight.
// Ports    : Clk, Rst_n (async active-low)
//            Start/Op/OpA/OpB          - op request from decode
//            ReadReq                   - mfhi/mflo present in decode
//            ReadHi/ReadLo             - current HiLo contents
//            Busy/Stall/Done           - status
//            WriteHiData/WriteLoData   - result data, qualified by strobes
//            WriteEn/Madd/Msub         - HiLo write strobes (one-hot)
//            DivZero                   - only with HILO_DIVZERO_FLAG_EN
// Config   : define HILO_DIVZERO_FLAG_EN to add the DivZero output.
// Revision : 1.0  initial release
// ============================================================================
module hilo_muldiv_ctrl
   import hilo_ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 4
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Start,
   input  logic [3:0]  Op,
   input  logic [31:0] OpA,
   input  logic [31:0] OpB,
   input  logic        ReadReq,
   input  logic [31:0] ReadHi,
   input  logic [31:0] ReadLo,
   output logic        Busy,
   output logic        Stall,
   output logic        Done,
   output logic [31:0] WriteHiData,
   output logic [31:0] WriteLoData,
   output logic        WriteEn,
   output logic        Madd,
   output logic        Msub
`ifdef HILO_DIVZERO_FLAG_EN
  ,output logic        DivZero
`endif
);

   localparam logic [3:0] C_MUL_LAST = 4'(MUL_LATENCY - 1);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [3:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_accept;
   logic        w_is_div;
   logic        w_is_mov;
   logic        w_div0;
   logic        w_sgn;
   logic        w_mul_last;
   strobe_t     w_stb;
   logic [63:0] w_a_ext;
   logic [63:0] w_b_ext;
   logic [63:0] w_prod;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic        w_div_go;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic        w_div_done;
   logic [31:0] w_hi_nxt;
   logic [31:0] w_lo_nxt;

   // ---------------------------------------------------------------- decode
   assign w_accept   = (r_state == ST_IDLE) && Start && (op_strobe(Op) != STB_NONE);
   assign w_is_div   = (Op == OP_DIV) || (Op == OP_DIVU);
   assign w_is_mov   = (Op == OP_MTHI) || (Op == OP_MTLO);
   assign w_div0     = w_is_div && (OpB == 32'd0);
   // Even codes among 0..7 are the signed variants.
   assign w_sgn      = ~Op[0];
   assign w_mul_last = (r_cnt == C_MUL_LAST);

   // ------------------------------------------------------------- multiply
   assign w_a_ext = (~r_op[0] && r_a[31]) ? {32'hFFFF_FFFF, r_a} : {32'd0, r_a};
   assign w_b_ext = (~r_op[0] && r_b[31]) ? {32'hFFFF_FFFF, r_b} : {32'd0, r_b};
   assign w_prod  = w_a_ext * w_b_ext;

   // --------------------------------------------------------------- divide
   assign w_mag_a  = (w_sgn && OpA[31]) ? -OpA : OpA;
   assign w_mag_b  = (w_sgn && OpB[31]) ? -OpB : OpB;
   assign w_div_go = w_accept && w_is_div && !w_div0;

   hilo_div_unit u_div (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Go        (w_div_go),
      .Dividend  (w_mag_a),
      .Divisor   (w_mag_b),
      .Quotient  (w_quo),
      .Remainder (w_rem),
      .DivDone   (w_div_done)
   );

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_stb   = op_strobe(r_op);
      Busy    = (r_state != ST_IDLE);
      Stall   = Busy && (Start || ReadReq);
      Done    = (r_state == ST_WRITE);
      WriteEn = Done && (w_stb == STB_WE);
      Madd    = Done && (w_stb == STB_MADD);
      Msub    = Done && (w_stb == STB_MSUB);
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_is_mov || w_div0) w_next = ST_WRITE;
               else if (w_is_div)      w_next = ST_DIV;
               else                    w_next = ST_MUL;
            end
         end
         ST_MUL:   if (w_mul_last) w_next = ST_WRITE;
         ST_DIV:   if (w_div_done) w_next = ST_FIX;
         ST_FIX:   w_next = ST_WRITE;
         ST_WRITE: w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Result data is registered on entry to WRITE and held afterwards.
   always_comb begin
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (w_accept && Op == OP_MTHI) begin
         w_hi_nxt = OpA;
         w_lo_nxt = ReadLo;
      end else if (w_accept && Op == OP_MTLO) begin
         w_hi_nxt = ReadHi;
         w_lo_nxt = OpA;
      end else if (w_accept && w_div0) begin
         w_hi_nxt = OpA;
         w_lo_nxt = 32'hFFFF_FFFF;
      end else if (r_state == ST_MUL && w_mul_last) begin
         w_hi_nxt = w_prod[63:32];
         w_lo_nxt = w_prod[31:0];
      end else if (r_state == ST_FIX) begin
         w_hi_nxt = r_neg_r ? -w_rem : w_rem;
         w_lo_nxt = r_neg_q ? -w_quo : w_quo;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= Op;
            r_a     <= OpA;
            r_b     <= OpB;
            r_neg_q <= w_sgn && (OpA[31] ^ OpB[31]);
            r_neg_r <= w_sgn && OpA[31];
         end
         r_cnt <= (r_state == ST_MUL) ? r_cnt + 4'd1 : 4'd0;
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
      end
   end

   assign WriteHiData = r_hi;
   assign WriteLoData = r_lo;

`ifdef HILO_DIVZERO_FLAG_EN
   logic r_divzero;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)        r_divzero <= 1'b0;
      else if (w_accept) r_divzero <= w_div0;
   end

   assign DivZero = Done && r_divzero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_ctrl
// Purpose  : Directed self-checking bench for hilo_muldiv_ctrl
//            (MUL_LATENCY = 4). Builds with or without HILO_DIVZERO_FLAG_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;
   import hilo_ctrl_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        read_req;
   logic [31:0] read_hi;
   logic [31:0] read_lo;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] wr_hi;
   logic [31:0] wr_lo;
   logic        we;
   logic        madd;
   logic        msub;
`ifdef HILO_DIVZERO_FLAG_EN
   logic        divzero;
`endif

   int n_checks = 0;
   int n_err    = 0;

   hilo_muldiv_ctrl #(.MUL_LATENCY(4)) dut (
      .Clk         (clk),
      .Rst_n       (rst_n),
      .Start       (start),
      .Op          (op),
      .OpA         (opa),
      .OpB         (opb),
      .ReadReq     (read_req),
      .ReadHi      (read_hi),
      .ReadLo      (read_lo),
      .Busy        (busy),
      .Stall       (stall),
      .Done        (done),
      .WriteHiData (wr_hi),
      .WriteLoData (wr_lo),
      .WriteEn     (we),
      .Madd        (madd),
      .Msub        (msub)
`ifdef HILO_DIVZERO_FLAG_EN
     ,.DivZero     (divzero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge; the request is accepted at the next edge.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      opa   = a;
      opb   = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called right after the accepting edge N; the strobe is expected after
   // edge N+k, with nothing beforehand and Busy/Done clear afterwards.
   task automatic expect_op(input string tag, input int k, input logic [3:0] stb,
                            input logic [31:0] hi, input logic [31:0] lo);
      for (int i = 0; i < k; i++) begin
         chk({tag, "_quiet"}, {60'd0, we, madd, msub, done}, 64'd0);
         @(posedge clk); #1;
      end
      chk({tag, "_strobe"}, {60'd0, we, madd, msub, done}, {60'd0, stb});
      chk({tag, "_hi"}, {32'd0, wr_hi}, {32'd0, hi});
      chk({tag, "_lo"}, {32'd0, wr_lo}, {32'd0, lo});
      chk({tag, "_busy_wr"}, {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      chk({tag, "_after"}, {59'd0, busy, we, madd, msub, done}, 64'd0);
      chk({tag, "_hold_hi"}, {32'd0, wr_hi}, {32'd0, hi});
   endtask

   initial begin
      int n_stb;
      rst_n    = 1'b0;
      start    = 1'b0;
      op       = 4'd0;
      opa      = 32'd0;
      opb      = 32'd0;
      read_req = 1'b0;
      read_hi  = 32'd0;
      read_lo  = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", {60'd0, busy, stall, done, we}, 64'd0);
      chk("reset_data", {wr_hi, wr_lo}, 64'd0);
      chk("reset_acc", {62'd0, madd, msub}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Signed multiply: -3 * 7 = -21
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
      expect_op("mult", 4, 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      // Unsigned multiply of large operands
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      expect_op("multu", 4, 4'b1001, 32'h0000_0001, 32'hFFFF_FFFE);

      issue(OP_MADDU, 32'h0001_0000, 32'h0001_0000);
      expect_op("maddu", 4, 4'b0101, 32'h0000_0001, 32'h0000_0000);

      issue(OP_MSUB, 32'h0001_0000, 32'h0001_0000);
      expect_op("msub", 4, 4'b0011, 32'h0000_0001, 32'h0000_0000);

      // Signed divide: -7 / 2 = -3 rem -1
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
`ifdef HILO_DIVZERO_FLAG_EN
      repeat (34) @(posedge clk);
      #1;
      chk("div_nz_flag", {63'd0, divzero}, 64'd0);
      @(posedge clk); #1;
`else
      expect_op("div_neg", 34, 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`endif

      // Signed divide: 7 / -2 = -3 rem 1
      issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
      expect_op("div_negb", 34, 4'b1001, 32'h0000_0001, 32'hFFFF_FFFD);

      // Overflow case
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      expect_op("div_ovf", 34, 4'b1001, 32'h0000_0000, 32'h8000_0000);

      issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
      expect_op("divu", 34, 4'b1001, 32'h0000_0001, 32'h7FFF_FFFC);

      // Divide by zero: no iterations, Hi = OpA, Lo = all ones
      issue(OP_DIVU, 32'd100, 32'd0);
`ifdef HILO_DIVZERO_FLAG_EN
      chk("divzero_flag", {63'd0, divzero}, 64'd1);
`endif
      expect_op("divu_zero", 0, 4'b1001, 32'd100, 32'hFFFF_FFFF);

      issue(OP_DIV, 32'hFFFF_FFF0, 32'd0);
      expect_op("div_zero", 0, 4'b1001, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

      // Moves
      read_hi = 32'h5555;
      read_lo = 32'hABCD;
      issue(OP_MTHI, 32'h1234, 32'd0);
      read_lo = 32'h0;
      expect_op("mthi", 0, 4'b1001, 32'h1234, 32'hABCD);

      read_hi = 32'h5555;
      issue(OP_MTLO, 32'h9999, 32'd0);
      read_hi = 32'h0;
      expect_op("mtlo", 0, 4'b1001, 32'h5555, 32'h9999);

      // Reserved op code is ignored
      issue(4'd12, 32'h1, 32'h1);
      chk("rsvd_busy", {59'd0, busy, we, madd, msub, done}, 64'd0);
      @(posedge clk); #1;
      chk("rsvd_busy2", {59'd0, busy, we, madd, msub, done}, 64'd0);

      // Hazard: ReadReq held across a MULT, plus a Start during Busy
      read_req = 1'b1;
      start    = 1'b1;
      op       = OP_MULT;
      opa      = 32'd6;
      opb      = 32'd7;
      chk("stall_pre", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
      n_stb = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) begin
            start = 1'b1;
            op    = OP_MADD;
         end
         if (i == 2) start = 1'b0;
         chk("hz_stall", {63'd0, stall}, {63'd0, (i <= 4)});
         n_stb += int'(we) + int'(madd) + int'(msub);
         @(posedge clk); #1;
      end
      chk("hz_strobes", 64'(n_stb), 64'd1);
      chk("hz_data", {wr_hi, wr_lo}, 64'd42);
      read_req = 1'b0;

      // Reset in the middle of a divide
      issue(OP_DIV, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #1;
      chk("mid_busy", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_ctrl", {59'd0, busy, we, madd, msub, done}, 64'd0);
      chk("rst_data", {wr_hi, wr_lo}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_stb = 0;
      for (int i = 0; i < 40; i++) begin
         n_stb += int'(we) + int'(madd) + int'(msub) + int'(done) + int'(busy);
         @(posedge clk); #1;
      end
      chk("rst_nostrobe", 64'(n_stb), 64'd0);

      issue(OP_MULT, 32'd3, 32'd5);
      expect_op("mult_post", 4, 4'b1001, 32'd0, 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
